// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: one state per cycle, outputs decoded combinationally from state.
// Memory states stall on mem_ready; an optional wait counter traps a hung memory.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic       trap,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    UPPER    = 4'd11,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
  localparam int             CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  TMAX   = CW'(TIMEOUT_CYCLES);
  localparam bit             TO_EN  = (TIMEOUT_CYCLES > 0);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  logic          br_ok;

  logic mem_req_raw;
  logic ir_write_raw;
  logic pc_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic trap_raw;

  function automatic logic is_wait(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

  assign timeout = TO_EN && (wait_cnt == TMAX) && !mem_ready;
  assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);

  always_comb begin
    state_n = state;
    case (state)
      FETCH: begin
        if (mem_ready)    state_n = DECODE;
        else if (timeout) state_n = TRAP;
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_RTYPE:          state_n = EXECR;
          OP_ITYPE:          state_n = EXECI;
          OP_BRANCH:         state_n = BRANCH;
          OP_JAL:            state_n = JAL;
          OP_LUI, OP_AUIPC:  state_n = UPPER;
          default:           state_n = TRAP;
        endcase
      end
      MEMADR:   state_n = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (mem_ready)    state_n = MEMWB;
        else if (timeout) state_n = TRAP;
      end
      MEMWB:    state_n = FETCH;
      MEMWRITE: begin
        if (mem_ready)    state_n = FETCH;
        else if (timeout) state_n = TRAP;
      end
      EXECR:    state_n = ALUWB;
      EXECI:    state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = br_ok ? FETCH : TRAP;
      JAL:      state_n = ALUWB;
      UPPER:    state_n = ALUWB;
      TRAP:     state_n = TRAP;
      default:  state_n = TRAP;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (mem_ready || ((state_n != state) && is_wait(state_n)))
        wait_cnt <= '0;
      else if (is_wait(state) && (wait_cnt != TMAX))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_req_raw   = 1'b0;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 3'b000;
    trap_raw      = 1'b0;
    case (state)
      FETCH: begin
        mem_req_raw  = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = 3'b010;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      DECODE: begin
        // Branch target is computed here so BRANCH can load PC from ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
      end
      MEMREAD: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        mem_req_raw   = 1'b1;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 3'b000;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 3'b011;
      end
      ALUWB: begin
        result_src    = 2'b00;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        alu_op       = 3'b001;
        result_src   = 2'b00;
        pc_write_raw = br_ok && (zero ^ funct3[0]);
      end
      JAL: begin
        // ALU forms OldPC+4 for the link write in ALUWB.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        alu_op       = 3'b010;
        result_src   = 2'b00;
        pc_write_raw = 1'b1;
      end
      UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 3'b100;
      end
      TRAP:    trap_raw = 1'b1;
      default: trap_raw = 1'b0;
    endcase
  end

  // Reset gates the strobes combinationally so an in-flight access drops at once.
  assign mem_req   = mem_req_raw   & ~RST;
  assign ir_write  = ir_write_raw  & ~RST;
  assign pc_write  = pc_write_raw  & ~RST;
  assign mem_write = mem_write_raw & ~RST;
  assign reg_write = reg_write_raw & ~RST;
  assign trap      = trap_raw      & ~RST;
  assign state_o   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks with hand-computed expectations.
module tb_multicycle_control;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  int total = 0;
  int bad = 0;

  multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .trap(trap), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Leaves the DUT in FETCH, mid-cycle, with mem_ready low.
  task automatic rst_pulse();
    mem_ready = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; mem_ready = 1'b1; #3;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin bad++; $display("FAIL rst_enables ir=%b pc=%b exp=0", ir_write, pc_write); end
    total++; if (trap !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_misc trap=%b rw=%b mw=%b exp=0", trap, reg_write, mem_write); end
    rst_pulse();
    total++; if (state_o !== 4'd0 || mem_req !== 1'b1) begin bad++; $display("FAIL fetch_after_rst state=%0d req=%b exp=0/1", state_o, mem_req); end
    total++; if (alu_src_b !== 2'b10 || alu_op !== 3'b010 || result_src !== 2'b10 || adr_src !== 1'b0) begin bad++; $display("FAIL fetch_ctl b=%b op=%b rs=%b adr=%b exp=10/010/10/0", alu_src_b, alu_op, result_src, adr_src); end
    total++; if (ir_write !== 1'b0) begin bad++; $display("FAIL fetch_irw_noready got=%b exp=0", ir_write); end
  endtask

  task automatic test_add();
    rst_pulse();
    opcode = 7'b0110011; mem_ready = 1'b1; #1;
    total++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin bad++; $display("FAIL add_fetch_wr ir=%b pc=%b exp=1", ir_write, pc_write); end
    tick(); mem_ready = 1'b0; #1;
    total++; if (state_o !== 4'd1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || alu_op !== 3'b010) begin bad++; $display("FAIL add_decode st=%0d a=%b b=%b op=%b exp=1/01/01/010", state_o, alu_src_a, alu_src_b, alu_op); end
    tick(); #1;
    total++; if (state_o !== 4'd6 || alu_op !== 3'b000 || alu_src_a !== 2'b10 || reg_write !== 1'b0) begin bad++; $display("FAIL add_execr st=%0d op=%b a=%b rw=%b exp=6/000/10/0", state_o, alu_op, alu_src_a, reg_write); end
    tick(); #1;
    total++; if (state_o !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00) begin bad++; $display("FAIL add_aluwb st=%0d rw=%b rs=%b exp=8/1/00", state_o, reg_write, result_src); end
    tick(); #1;
    total++; if (state_o !== 4'd0 || reg_write !== 1'b0) begin bad++; $display("FAIL add_back st=%0d rw=%b exp=0/0", state_o, reg_write); end
  endtask

  task automatic test_addi_lw();
    rst_pulse();
    opcode = 7'b0010011; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (state_o !== 4'd7 || alu_op !== 3'b011 || alu_src_b !== 2'b01) begin bad++; $display("FAIL addi_execi st=%0d op=%b b=%b exp=7/011/01", state_o, alu_op, alu_src_b); end
    tick(); tick();
    opcode = 7'b0000011; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (state_o !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin bad++; $display("FAIL lw_memadr st=%0d a=%b b=%b exp=2/10/01", state_o, alu_src_a, alu_src_b); end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      total++; if (state_o !== 4'd3 || mem_req !== 1'b1 || adr_src !== 1'b1) begin bad++; $display("FAIL lw_memread cyc=%0d st=%0d req=%b adr=%b exp=3/1/1", i, state_o, mem_req, adr_src); end
      tick();
    end
    mem_ready = 1'b0; #1;
    total++; if (state_o !== 4'd4 || result_src !== 2'b01 || reg_write !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL lw_memwb st=%0d rs=%b rw=%b req=%b exp=4/01/1/0", state_o, result_src, reg_write, mem_req); end
    tick(); #1;
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL lw_back st=%0d exp=0", state_o); end
  endtask

  task automatic test_branch();
    logic [2:0] f3  [3] = '{3'b000, 3'b001, 3'b001};
    logic       zv  [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst_pulse();
      opcode = 7'b1100011; funct3 = f3[i]; zero = zv[i];
      mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
      total++; if (state_o !== 4'd9 || alu_op !== 3'b001 || pc_write !== exp[i]) begin bad++; $display("FAIL branch_%0d st=%0d op=%b pcw=%b exp=9/001/%b", i, state_o, alu_op, pc_write, exp[i]); end
      tick(); #1;
      total++; if (state_o !== 4'd0) begin bad++; $display("FAIL branch_next_%0d st=%0d exp=0", i, state_o); end
    end
    rst_pulse();
    funct3 = 3'b100; zero = 1'b1;
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL branch_bad_f3_pcw got=%b exp=0", pc_write); end
    tick(); #1;
    total++; if (state_o !== 4'd15 || trap !== 1'b1) begin bad++; $display("FAIL branch_bad_f3_trap st=%0d trap=%b exp=15/1", state_o, trap); end
    funct3 = 3'b000; zero = 1'b0;
  endtask

  task automatic test_jal_upper();
    rst_pulse();
    opcode = 7'b1101111; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (state_o !== 4'd10 || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin bad++; $display("FAIL jal st=%0d pcw=%b a=%b b=%b exp=10/1/01/10", state_o, pc_write, alu_src_a, alu_src_b); end
    tick(); #1;
    total++; if (state_o !== 4'd8 || reg_write !== 1'b1) begin bad++; $display("FAIL jal_wb st=%0d rw=%b exp=8/1", state_o, reg_write); end
    tick();
    opcode = 7'b0110111; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (state_o !== 4'd11 || alu_src_a !== 2'b11 || alu_op !== 3'b100 || alu_src_b !== 2'b01) begin bad++; $display("FAIL lui st=%0d a=%b op=%b b=%b exp=11/11/100/01", state_o, alu_src_a, alu_op, alu_src_b); end
    tick(); tick();
    opcode = 7'b0010111; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); #1;
    total++; if (state_o !== 4'd11 || alu_src_a !== 2'b01) begin bad++; $display("FAIL auipc st=%0d a=%b exp=11/01", state_o, alu_src_a); end
  endtask

  task automatic test_store_reset();
    rst_pulse();
    opcode = 7'b0100011; mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick(); tick(); #1;
    total++; if (state_o !== 4'd5 || mem_write !== 1'b1 || mem_req !== 1'b1 || adr_src !== 1'b1) begin bad++; $display("FAIL sw_memwrite st=%0d mw=%b req=%b adr=%b exp=5/1/1/1", state_o, mem_write, mem_req, adr_src); end
    RST = 1'b1; #1;
    total++; if (mem_write !== 1'b0 || mem_req !== 1'b0 || state_o !== 4'd0) begin bad++; $display("FAIL sw_rst mw=%b req=%b st=%0d exp=0/0/0", mem_write, mem_req, state_o); end
    tick(); RST = 1'b0; mem_ready = 1'b1; #1;
    total++; if (state_o !== 4'd0 || mem_req !== 1'b1) begin bad++; $display("FAIL sw_release st=%0d req=%b exp=0/1", state_o, mem_req); end
    tick(); mem_ready = 1'b0; #1;
    total++; if (state_o !== 4'd1) begin bad++; $display("FAIL sw_release_next st=%0d exp=1", state_o); end
  endtask

  task automatic test_illegal();
    rst_pulse();
    opcode = 7'b0000000; mem_ready = 1'b1; tick(); tick(); #1;
    total++; if (state_o !== 4'd15 || trap !== 1'b1 || mem_req !== 1'b0 || ir_write !== 1'b0) begin bad++; $display("FAIL illegal st=%0d trap=%b req=%b irw=%b exp=15/1/0/0", state_o, trap, mem_req, ir_write); end
    tick(); tick(); #1;
    total++; if (state_o !== 4'd15 || trap !== 1'b1) begin bad++; $display("FAIL illegal_hold st=%0d trap=%b exp=15/1", state_o, trap); end
  endtask

  task automatic test_timeout();
    // mem_ready arriving on the counter-at-limit cycle beats the timeout
    rst_pulse();
    opcode = 7'b0110011;
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; #1;
    total++; if (state_o !== 4'd1) begin bad++; $display("FAIL to_priority st=%0d exp=1", state_o); end
    rst_pulse();
    for (int i = 0; i < 16; i++) begin
      total++; if (state_o !== 4'd0) begin bad++; $display("FAIL to_fetch cyc=%0d st=%0d exp=0", i, state_o); end
      tick();
    end
    #1;
    total++; if (state_o !== 4'd15 || trap !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL to_trap st=%0d trap=%b req=%b exp=15/1/0", state_o, trap, mem_req); end
    mem_ready = 1'b1; tick(); tick(); #1;
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL to_persist trap=%b exp=1", trap); end
    RST = 1'b1; #1;
    total++; if (trap !== 1'b0 || state_o !== 4'd0) begin bad++; $display("FAIL to_rst trap=%b st=%0d exp=0/0", trap, state_o); end
    RST = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi_lw();
    test_branch();
    test_jal_upper();
    test_store_reset();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: max memory-wait cycles before trap; 0 disables the timeout.
REQ-002 SHALL have port CLK  in  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  in  7  instruction register opcode field, stable from DECODE onward.
REQ-005 SHALL have port funct3  in  3  instruction register funct3 field.
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  in  1  memory completes the current access this cycle.
REQ-008 SHALL have port mem_req  out  1  memory access request, held until mem_ready.
REQ-009 SHALL have port adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 SHALL have port ir_write  out  1  load instruction and OldPC registers.
REQ-011 SHALL have port pc_write  out  1  load PC from result bus.
REQ-012 SHALL have port mem_write  out  1  store strobe, qualified by mem_req.
REQ-013 SHALL have port reg_write  out  1  register file write enable.
REQ-014 SHALL have port alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg, 11=zero.
REQ-015 SHALL have port alu_src_b  out  2  00=rs2 reg, 01=immediate, 10=constant 4.
REQ-016 SHALL have port result_src  out  2  00=ALUOut, 01=memory data, 10=ALU result.
REQ-017 SHALL have port alu_op  out  3  to ALU_CONTROL: 000 R, 001 branch, 010 add, 011 I-ALU, 100 LUI/AUIPC.
REQ-018 SHALL have port trap  out  1  high while in TRAP.
REQ-019 SHALL have port state_o  out  4  current state encoding.

Function
REQ-020 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, UPPER=11, TRAP=15. Codes 12-14 SHALL go to TRAP.
REQ-021 Outputs not listed for a state SHALL be 0. Outputs SHALL be combinational from state, and from the mem_ready, zero and opcode inputs where stated.
REQ-022 FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=010, result_src=10. ir_write=pc_write=mem_ready. On mem_ready go to DECODE, else stay.
REQ-023 DECODE: a=01, b=01, alu_op=010 (branch target into ALUOut). Next state by opcode: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; 0110111/0010111->UPPER; any other->TRAP.
REQ-024 MEMADR: a=10, b=01, alu_op=010. Go to MEMREAD if opcode=0000011, else MEMWRITE.
REQ-025 MEMREAD: mem_req=1, adr_src=1. Go to MEMWB on mem_ready.
REQ-026 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-027 MEMWRITE: mem_req=1, adr_src=1, mem_write=1. Go to FETCH on mem_ready.
REQ-028 EXECR: a=10, b=00, alu_op=000, then ALUWB. EXECI: a=10, b=01, alu_op=011, then ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-030 BRANCH: a=10, b=00, alu_op=001, result_src=00. pc_write = zero XOR funct3[0], then FETCH. funct3 other than 000 or 001 SHALL go to TRAP with pc_write=0.
REQ-031 JAL: a=01, b=10, alu_op=010, result_src=00, pc_write=1, then ALUWB (rd <- OldPC+4).
REQ-032 UPPER: a=11 for opcode 0110111 and a=01 for 0010111; b=01, alu_op=100, then ALUWB.
REQ-033 Wait counter, width clog2(TIMEOUT_CYCLES+1):
- clears on entry to FETCH, MEMREAD or MEMWRITE and on any cycle with mem_ready=1;
- increments each wait cycle with mem_req=1 and mem_ready=0, saturating at TIMEOUT_CYCLES.
REQ-034 If TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES with mem_ready=0, the next state SHALL be TRAP. mem_ready in that same cycle SHALL take priority over the timeout.
REQ-035 TRAP: trap=1, all enables and mem_req 0. TRAP SHALL persist until RST.

Reset
REQ-036 While RST is high: state=FETCH, counter=0, and mem_req, ir_write, pc_write, mem_write, reg_write, trap all forced 0; state_o=0.
REQ-037 RST asserted mid-access SHALL drop mem_req immediately. After RST deasserts, the first edge SHALL evaluate FETCH.

Verification
REQ-038 add (0110011), mem_ready=1 in fetch -> states 0,1,6,8,0; alu_op=000 in EXECR; reg_write=1 only in ALUWB.
REQ-039 lw, mem_ready delayed 3 cycles in MEMREAD -> mem_req=1 and adr_src=1 held for 4 cycles; then MEMWB with result_src=01.
REQ-040 beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0; funct3=100 -> TRAP.
REQ-041 TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> TRAP entered after 16 FETCH cycles; trap=1 until RST.
REQ-042 Illegal opcode 0000000 -> DECODE to TRAP. RST asserted in MEMWRITE -> mem_write=0 at once; FETCH after release.
